// File: rtl/trisc_pkg.sv
// Shared types for the trisc accumulator core: opcodes, FSM states, ALU ops, flag indices.
// Status state codes fold EXEC and MEMOP onto one reported value.
package trisc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LDA = 4'h2,
        OP_STA = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_JC  = 4'hA,
        OP_INC = 4'hB,
        OP_CLR = 4'hC,
        OP_OUT = 4'hD,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMOP
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_INC
    } alu_op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    localparam logic [1:0] CODE_HALT   = 2'd0;
    localparam logic [1:0] CODE_FETCH  = 2'd1;
    localparam logic [1:0] CODE_DECODE = 2'd2;
    localparam logic [1:0] CODE_EXEC   = 2'd3;

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            ST_HALT:   return CODE_HALT;
            ST_FETCH:  return CODE_FETCH;
            ST_DECODE: return CODE_DECODE;
            default:   return CODE_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/trisc_alu.sv
// Combinational ALU for the trisc core: add/sub/and/or/inc/pass with C, V, Z.
// Zero latency, no flow control; C on SUB is borrow (a < b).
module trisc_alu import trisc_pkg::*; #(
    parameter int DW = 4
) (
    input  alu_op_t       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          v,
    output logic          z
);

    logic [DW:0] sum;

    always_comb begin
        sum    = '0;
        result = b;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DW-1:0];
                c      = sum[DW];
                v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                // Top bit of the widened difference is the borrow.
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DW-1:0];
                c      = sum[DW];
                v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_INC: begin
                sum    = {1'b0, a} + (DW+1)'(1);
                result = sum[DW-1:0];
                c      = sum[DW];
                v      = !a[DW-1] && result[DW-1];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = b;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/trisc_core.sv
// Multi-cycle accumulator CPU: 3 cycles per register/branch op, 4 per memory-operand op.
// No backpressure; RAM is loaded through the prog_* port only while halted in program mode.
module trisc_core import trisc_pkg::*; #(
    parameter  int DW = 4,
    parameter  int AW = 4,
    localparam int IW = 4 + AW
) (
    input  logic          SysClock,
    input  logic          StartStop,
    input  logic          Mode,
    input  logic          Run,
    input  logic          ClearPC,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] ir,
    output logic [DW-1:0] acc,
    output logic [2:0]    flags,
    output logic [1:0]    state,
    output logic          halted,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    state_t        cur, nxt;
    logic [IW-1:0] mem [2**AW];
    logic [IW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [IW-1:0] ram_wdata;
    logic          ram_we;

    opcode_t       op;
    logic [AW-1:0] operand;
    logic [DW-1:0] imm, m;
    alu_op_t       alu_op;
    logic [DW-1:0] alu_b, alu_res;
    logic          alu_c, alu_v, alu_z;

    assign op      = opcode_t'(ir[IW-1:AW]);
    assign operand = ir[AW-1:0];
    assign imm     = DW'(operand);
    assign m       = DW'(rdata);

    assign state  = state_code(cur);
    assign halted = (cur == ST_HALT);

    always_comb begin
        ram_addr  = pc;
        ram_wdata = prog_data;
        ram_we    = 1'b0;
        case (cur)
            ST_HALT: begin
                if (Mode) ram_addr = prog_addr;
                ram_we = Mode && prog_we;
            end
            ST_EXEC: begin
                ram_addr  = operand;
                ram_wdata = IW'(acc);
                ram_we    = (op == OP_STA);
            end
            default: ;
        endcase
        // A write in the reset cycle would be a partial commit.
        if (!StartStop) ram_we = 1'b0;
    end

    always_ff @(posedge SysClock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rdata <= mem[ram_addr];
    end

    always_ff @(posedge SysClock) begin
        if (!StartStop) cur <= ST_HALT;
        else            cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_HALT:   if (!Mode && Run && !ClearPC) nxt = ST_FETCH;
            ST_FETCH:  nxt = ST_DECODE;
            ST_DECODE: nxt = ST_EXEC;
            ST_EXEC: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: nxt = ST_MEMOP;
                    OP_HLT:  nxt = ST_HALT;
                    default: nxt = ST_FETCH;
                endcase
            end
            ST_MEMOP:  nxt = ST_FETCH;
            default:   nxt = ST_HALT;
        endcase
    end

    always_comb begin
        alu_op = ALU_PASS;
        case (op)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_INC:  alu_op = ALU_INC;
            default: alu_op = ALU_PASS;
        endcase
    end

    assign alu_b = (cur == ST_MEMOP) ? m : imm;

    trisc_alu #(.DW(DW)) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (alu_b),
        .result (alu_res),
        .c      (alu_c),
        .v      (alu_v),
        .z      (alu_z)
    );

    always_ff @(posedge SysClock) begin
        if (!StartStop) begin
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            flags     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (cur)
                ST_HALT: if (ClearPC) pc <= '0;
                ST_DECODE: begin
                    ir <= rdata;
                    pc <= pc + AW'(1);
                end
                ST_EXEC: begin
                    case (op)
                        OP_LDI: begin
                            acc           <= alu_res;
                            flags[FLAG_Z] <= alu_z;
                        end
                        OP_INC: begin
                            acc           <= alu_res;
                            flags[FLAG_Z] <= alu_z;
                            flags[FLAG_C] <= alu_c;
                            flags[FLAG_V] <= alu_v;
                        end
                        OP_CLR: begin
                            acc           <= '0;
                            flags[FLAG_Z] <= 1'b1;
                            flags[FLAG_C] <= 1'b0;
                            flags[FLAG_V] <= 1'b0;
                        end
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_JMP: pc <= operand;
                        OP_JZ:  if (flags[FLAG_Z]) pc <= operand;
                        OP_JC:  if (flags[FLAG_C]) pc <= operand;
                        default: ;
                    endcase
                end
                ST_MEMOP: begin
                    case (op)
                        OP_LDA, OP_AND, OP_OR: begin
                            acc           <= alu_res;
                            flags[FLAG_Z] <= alu_z;
                        end
                        OP_ADD, OP_SUB: begin
                            acc           <= alu_res;
                            flags[FLAG_Z] <= alu_z;
                            flags[FLAG_C] <= alu_c;
                            flags[FLAG_V] <= alu_v;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/trisc_core.md
Name: trisc_core

Overview:
- Parametrised successor to the fixed 4-bit TRISC2 datapath/control pair.
- Multi-cycle accumulator processor containing:
  - program/data RAM with synchronous read;
  - PC, IR, ACC and a Z/C/V flag register;
  - an ALU;
  - a one-hot-free encoded control FSM.
- Adds conditional branches, flags, HLT/resume and an OUT port.
- Program mode loads RAM from external switches while the core is halted; run mode executes from PC.

Parameters:
DW, 4, accumulator/data width (>=2)
AW, 4, address width; RAM depth = 2^AW; instruction word IW = 4 + AW

Ports:
SysClock  in  1  single clock, all state on rising edge
StartStop  in  1  synchronous active-low reset
Mode  in  1  1 = program mode (RAM load), 0 = run mode
Run  in  1  level; sampled in HALT, starts/resumes execution
ClearPC  in  1  in HALT: PC <= 0
prog_we  in  1  program-mode RAM write strobe
prog_addr  in  AW  program-mode RAM address
prog_data  in  IW  program-mode RAM write data
pc  out  AW  program counter
ir  out  IW  instruction register
acc  out  DW  accumulator
flags  out  3  {V,C,Z}
state  out  2  FSM state code
halted  out  1  1 in HALT
out_data  out  DW  register loaded by OUT
out_valid  out  1  one-cycle pulse on OUT

Behaviour:
- Reset (StartStop=0 at clock edge):
  - pc, ir, acc, flags, out_data, out_valid <= 0; state <= HALT.
  - RAM contents are not cleared.
  - Reset mid-instruction abandons it with no partial commit.
- Instruction format: opcode = word[IW-1:AW]; operand = word[AW-1:0]. Immediate = operand zero-extended (AW<DW) or truncated (AW>DW) to DW.
- RAM is 2^AW x IW with synchronous read (data valid the cycle after the address is presented) and synchronous write.
  - Address mux: program mode -> prog_addr; FETCH -> pc; EXEC -> operand.
  - STA writes {0, acc} zero-extended into the low DW bits.
- FSM states (state codes): HALT=0, FETCH=1, DECODE=2, EXEC=3, MEMOP encoded as 3 with an internal sub-flag is forbidden; the FSM uses 5 states, and the 2-bit state output reports HALT=0, FETCH=1, DECODE=2, EXEC/MEMOP=3.
  - HALT: if Mode=1 and prog_we, write RAM. If Mode=0 and Run=1 -> FETCH. ClearPC has priority over Run (same cycle: PC <= 0, stay HALT). prog_we is ignored outside HALT; Mode=1 blocks Run.
  - FETCH: present pc -> DECODE.
  - DECODE: ir <= rdata; pc <= pc+1, wrapping 2^AW-1 -> 0 -> EXEC.
  - EXEC: present operand address, then execute:
    - Single-cycle ops commit here -> FETCH.
    - LDA/ADD/SUB/AND/OR -> MEMOP.
    - HLT -> HALT.
  - MEMOP: use rdata[DW-1:0] as M; commit -> FETCH.
- Latency: register/branch ops take 3 cycles; memory-operand ops take 4.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc <= imm; Z.
  - 2 LDA: acc <= M; Z.
  - 3 STA.
  - 4 ADD: {C,acc} <= acc+M; V = signed overflow; Z.
  - 5 SUB: acc <= acc-M; C = borrow (acc<M); V = signed overflow; Z.
  - 6 AND: Z only.
  - 7 OR: Z only.
  - 8 JMP: pc <= operand.
  - 9 JZ: branch if Z.
  - A JC: branch if C.
  - B INC: acc+1; C set on wrap to 0; V on signed overflow; Z.
  - C CLR: acc <= 0; Z <= 1; C, V <= 0.
  - D OUT: out_data <= acc; out_valid = 1 for exactly one cycle.
  - F HLT.
  - E and undefined opcodes execute as NOP.
- Flags not listed for an op keep their value.
- HLT leaves pc = address after HLT; a later Run resumes from there.
- A jump to the current address loops legally with no special case.

Decomposition:
- Package trisc_pkg holds the opcode enum (4 bits), the FSM state enum, the flag bit indices and the status state-code constants.
- One natural sub-module, trisc_alu, is parametrised by DW: ops ADD/SUB/AND/OR/INC/PASS; outputs result, C, V, Z.
- RAM, FSM, PC, IR and ACC stay in trisc_core.

Test Plan:
- Reset then load RAM[0..3] = {LDI 5, ADD @8, OUT, HLT} with RAM[8] = 3; pulse Run -> out_data = 8 with out_valid high 1 cycle; halted after 14 cycles (3+4+3+3 + HALT entry); pc = 4.
- ACC = 0xF via LDI F, then INC -> acc = 0, Z = 1, C = 1, V = 0; SUB @addr (M=1) from acc=0 -> acc = 0xF, C = 1, V = 0.
- ADD: 7 + 1 (DW=4) -> acc = 8, V = 1, C = 0; then AND with 0 -> Z = 1, V and C unchanged.
- Branching: JZ taken when Z=1 loads pc = operand; JZ not taken falls through to pc+1. JMP from address 15 to 15, plus sequential fetch at 15 -> pc wraps to 0.
- Reset asserted during MEMOP of ADD -> acc and flags = 0, state = HALT; RAM contents unchanged. prog_we with Mode=1 while running -> no RAM write.
- Mode=1 with Run=1 in HALT -> stays halted; ClearPC and Run in the same cycle -> pc = 0, still HALT. Repeat the first test with DW=8, AW=6 to check parametrisation.
